// File: rtl/ram_access_scheduler_if.sv
// ---------------------------------------------------------------------------
// ram_access_scheduler_if
//   Groups the chipset bus, the image-loader port and the RAM controller
//   handshake that the RAM access scheduler arbitrates.
//
//   Handshake rules:
//     - ram_request is raised by the scheduler and held, together with
//       ram_write/ram_refresh/ram_address/ram_write_data, until the RAM
//       controller answers with a one-cycle ram_done pulse (read data valid
//       with ram_done). ram_request falls the cycle after ram_done.
//     - load_request is a level held by the loader until it sees the
//       one-cycle load_ack pulse.
//     - memory_access_ready low means the bus must insert wait states.
//
//   Modports:
//     master : the scheduler (drives RAM requests, ready, read data, ack)
//     slave  : the environment (bus, loader and RAM controller side)
// ---------------------------------------------------------------------------
interface ram_access_scheduler_if #(
    parameter int ADDR_WIDTH = 20
);
    // chipset bus side
    logic [ADDR_WIDTH-1:0] address;
    logic [7:0]            internal_data_bus;
    logic                  memory_read_n;
    logic                  memory_write_n;
    logic                  ram_address_select_n;
    logic                  memory_access_ready;
    logic [7:0]            bus_read_data;
    // image loader side
    logic                  load_request;
    logic [ADDR_WIDTH-1:0] load_address;
    logic [7:0]            load_data;
    logic                  load_ack;
    // RAM controller side
    logic                  ram_request;
    logic                  ram_write;
    logic                  ram_refresh;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [7:0]            ram_write_data;
    logic [7:0]            ram_read_data;
    logic                  ram_done;
    // status
    logic                  refresh_overrun;

    modport master (
        input  address, internal_data_bus, memory_read_n, memory_write_n,
               ram_address_select_n, load_request, load_address, load_data,
               ram_read_data, ram_done,
        output memory_access_ready, bus_read_data, load_ack, ram_request,
               ram_write, ram_refresh, ram_address, ram_write_data,
               refresh_overrun
    );

    modport slave (
        output address, internal_data_bus, memory_read_n, memory_write_n,
               ram_address_select_n, load_request, load_address, load_data,
               ram_read_data, ram_done,
        input  memory_access_ready, bus_read_data, load_ack, ram_request,
               ram_write, ram_refresh, ram_address, ram_write_data,
               refresh_overrun
    );
endinterface

// File: rtl/ram_access_scheduler.sv
// ---------------------------------------------------------------------------
// ram_access_scheduler
//   Shares the single chipset RAM port between bus memory cycles, the ioctl
//   image loader and periodic refresh. Each access is sequenced through the
//   request/done handshake with the RAM controller; memory_access_ready holds
//   the bus in wait states until its access has completed.
//
//   Ports:
//     clock       in   chipset clock, all state on the rising edge
//     reset_n     in   asynchronous active-low reset
//     sif         --   bus / loader / RAM controller signals (master modport)
//     o_dbg_state out  current FSM state (IDLE=0, BUS_ACC=1, LOAD_ACC=2,
//                      REFRESH=3, BUS_HOLD=4)
// ---------------------------------------------------------------------------
module ram_access_scheduler #(
    parameter int ADDR_WIDTH       = 20,
    parameter int REFRESH_INTERVAL = 390
) (
    input  logic                        clock,
    input  logic                        reset_n,
    ram_access_scheduler_if.master      sif,
    output logic [2:0]                  o_dbg_state
);

    localparam int CW = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_BUS_ACC  = 3'd1,
        S_LOAD_ACC = 3'd2,
        S_REFRESH  = 3'd3,
        S_BUS_HOLD = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic                  r_bus_req_prev;
    logic                  r_bus_pending;
    logic [CW-1:0]         r_refresh_cnt;
    logic                  r_refresh_pending;
    logic                  r_refresh_overrun;
    logic                  r_ram_request;
    logic                  r_ram_write;
    logic                  r_ram_refresh;
    logic [ADDR_WIDTH-1:0] r_ram_address;
    logic [7:0]            r_ram_write_data;
    logic [7:0]            r_bus_read_data;
    logic                  r_load_ack;

    logic                  w_bus_req;
    logic                  w_bus_req_rise;
    logic                  w_wrap;
    logic                  w_in_access;
    logic                  w_done;
    logic                  w_grant;

    assign w_bus_req = ~sif.ram_address_select_n &
                       (~sif.memory_read_n | ~sif.memory_write_n);
    // Gated by reset_n so ready reads 1 while reset is held, even if a
    // strobe is already active.
    assign w_bus_req_rise = w_bus_req & ~r_bus_req_prev & reset_n;
    assign w_wrap = (r_refresh_cnt == CW'(REFRESH_INTERVAL - 1));
    assign w_in_access = (r_state == S_BUS_ACC) || (r_state == S_LOAD_ACC) ||
                         (r_state == S_REFRESH);
    // ram_request is only ever high inside an access state, so this also
    // discards stray done pulses seen in IDLE/BUS_HOLD.
    assign w_done = sif.ram_done & r_ram_request;
    assign w_grant = (r_state == S_IDLE) && (w_state_nx != S_IDLE);

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_refresh_pending)
                    w_state_nx = S_REFRESH;
                else if (r_bus_pending)
                    w_state_nx = S_BUS_ACC;
                // While the ack pulse is out the loader has not yet dropped
                // its level request; do not serve it a second time.
                else if (sif.load_request && !r_load_ack)
                    w_state_nx = S_LOAD_ACC;
            end
            S_BUS_ACC:  if (w_done) w_state_nx = S_BUS_HOLD;
            S_LOAD_ACC: if (w_done) w_state_nx = S_IDLE;
            S_REFRESH:  if (w_done) w_state_nx = S_IDLE;
            S_BUS_HOLD: if (sif.memory_read_n && sif.memory_write_n) w_state_nx = S_IDLE;
            default:    w_state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    // Bus cycle detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bus_req_prev <= 1'b0;
            r_bus_pending  <= 1'b0;
        end else begin
            r_bus_req_prev <= w_bus_req;
            if (w_bus_req_rise)
                r_bus_pending <= 1'b1;
            else if (r_state == S_BUS_ACC && w_done)
                r_bus_pending <= 1'b0;
        end
    end

    // Refresh timer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_refresh_cnt     <= '0;
            r_refresh_pending <= 1'b0;
            r_refresh_overrun <= 1'b0;
        end else begin
            r_refresh_cnt <= w_wrap ? '0 : r_refresh_cnt + CW'(1);
            if (w_wrap) begin
                r_refresh_pending <= 1'b1;
                // A refresh completing on the wrap cycle was served in time.
                if (r_refresh_pending && !(r_state == S_REFRESH && w_done))
                    r_refresh_overrun <= 1'b1;
            end else if (r_state == S_REFRESH && w_done) begin
                r_refresh_pending <= 1'b0;
            end
        end
    end

    // RAM request and access attributes; attributes are captured at grant so
    // they stay stable for the whole access even if the strobe moves.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ram_request    <= 1'b0;
            r_ram_write      <= 1'b0;
            r_ram_refresh    <= 1'b0;
            r_ram_address    <= '0;
            r_ram_write_data <= '0;
            r_bus_read_data  <= '0;
            r_load_ack       <= 1'b0;
        end else begin
            r_ram_request <= w_in_access && !w_done;
            r_load_ack    <= (r_state == S_LOAD_ACC) && w_done;
            if (r_state == S_BUS_ACC && w_done && !r_ram_write)
                r_bus_read_data <= sif.ram_read_data;
            if (w_grant) begin
                case (w_state_nx)
                    S_BUS_ACC: begin
                        r_ram_write      <= ~sif.memory_write_n;
                        r_ram_refresh    <= 1'b0;
                        r_ram_address    <= sif.address;
                        r_ram_write_data <= sif.internal_data_bus;
                    end
                    S_LOAD_ACC: begin
                        r_ram_write      <= 1'b1;
                        r_ram_refresh    <= 1'b0;
                        r_ram_address    <= sif.load_address;
                        r_ram_write_data <= sif.load_data;
                    end
                    default: begin
                        r_ram_write      <= 1'b0;
                        r_ram_refresh    <= 1'b1;
                        r_ram_address    <= '0;
                        r_ram_write_data <= '0;
                    end
                endcase
            end
        end
    end

    assign sif.memory_access_ready = ~(w_bus_req_rise | r_bus_pending);
    assign sif.bus_read_data       = r_bus_read_data;
    assign sif.load_ack            = r_load_ack;
    assign sif.ram_request         = r_ram_request;
    assign sif.ram_write           = r_ram_write;
    assign sif.ram_refresh         = r_ram_refresh;
    assign sif.ram_address         = r_ram_address;
    assign sif.ram_write_data      = r_ram_write_data;
    assign sif.refresh_overrun     = r_refresh_overrun;
    assign o_dbg_state             = r_state;

endmodule

// File: tb/tb_ram_access_scheduler.sv
module tb_ram_access_scheduler;

    localparam int N  = 64;
    localparam int AW = 20;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_BUS_HOLD = 3'd4;

    logic       clock;
    logic       reset_n;
    logic [2:0] dbg_state;

    ram_access_scheduler_if #(.ADDR_WIDTH(AW)) sif();

    ram_access_scheduler #(.ADDR_WIDTH(AW), .REFRESH_INTERVAL(N)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .sif         (sif),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_total = 0;
    int n_bad   = 0;

    // entry = {refresh, write, addr[19:0], data[7:0]}; for reads, data is
    // what the RAM model returns.
    logic [29:0] exp_q[$];
    int  ram_latency = 2;
    bit  ram_stall   = 1'b0;
    int  done_seen   = 0;
    int  req_rises   = 0;
    int  cyc         = 0;

    // cycle counter since reset release and ram_request rising-edge counter
    initial begin
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(posedge clock);
            if (!reset_n) cyc = 0;
            else cyc++;
            if (sif.ram_request && !req_prev) req_rises++;
            req_prev = sif.ram_request;
        end
    end

    // ---------------- RAM controller model / scoreboard ----------------
    initial begin
        bit          in_acc;
        int          lat;
        logic [7:0]  cur_rdata;
        logic [29:0] got;
        logic [29:0] exp_e;
        logic [29:0] exp_cmp;
        in_acc = 1'b0;
        lat = 0;
        cur_rdata = 8'h00;
        sif.ram_done = 1'b0;
        sif.ram_read_data = 8'h00;
        forever begin
            @(negedge clock);
            sif.ram_done = 1'b0;
            if (!reset_n) begin
                in_acc = 1'b0;
            end else if (in_acc) begin
                if (!ram_stall) begin
                    lat++;
                    if (lat >= ram_latency) begin
                        sif.ram_done = 1'b1;
                        sif.ram_read_data = cur_rdata;
                        in_acc = 1'b0;
                        done_seen++;
                    end
                end
            end else if (sif.ram_request) begin
                in_acc = 1'b1;
                lat = 0;
                got = {sif.ram_refresh, sif.ram_write, sif.ram_address,
                       sif.ram_write ? sif.ram_write_data : 8'h00};
                if (sif.ram_refresh && (exp_q.size() == 0 || exp_q[0][29] == 1'b0)) begin
                    cur_rdata = 8'h00;   // background refresh, not under test
                end else if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    cur_rdata = 8'h00;
                    $display("FAIL unexpected_access got=%h required=none", got);
                end else begin
                    exp_e = exp_q.pop_front();
                    cur_rdata = exp_e[7:0];
                    exp_cmp = {exp_e[29:8], exp_e[28] ? exp_e[7:0] : 8'h00};
                    n_total++;
                    if (got !== exp_cmp) begin
                        n_bad++;
                        $display("FAIL ram_access got=%h required=%h", got, exp_cmp);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset_n = 1'b0;
        ram_stall = 1'b0;
        exp_q.delete();
        sif.ram_address_select_n = 1'b1;
        sif.memory_read_n = 1'b1;
        sif.memory_write_n = 1'b1;
        sif.address = '0;
        sif.internal_data_bus = 8'h00;
        sif.load_request = 1'b0;
        sif.load_address = '0;
        sif.load_data = 8'h00;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic bus_strobe(input logic [AW-1:0] addr, input bit wr, input logic [7:0] data);
        sif.address = addr;
        sif.internal_data_bus = data;
        sif.ram_address_select_n = 1'b0;
        sif.memory_read_n = wr;
        sif.memory_write_n = ~wr;
    endtask

    task automatic bus_release();
        sif.ram_address_select_n = 1'b1;
        sif.memory_read_n = 1'b1;
        sif.memory_write_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int k;
        do_reset();
        @(negedge clock); #1;
        n_total++;
        if (sif.memory_access_ready !== 1'b1 || sif.ram_request !== 1'b0 ||
            sif.load_ack !== 1'b0 || sif.refresh_overrun !== 1'b0 ||
            sif.bus_read_data !== 8'h00 || dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_state got rdy=%b req=%b ack=%b ovr=%b rd=%h st=%0d required 1 0 0 0 00 0",
                     sif.memory_access_ready, sif.ram_request, sif.load_ack,
                     sif.refresh_overrun, sif.bus_read_data, dbg_state);
        end
        // reset in the middle of a stalled bus write
        ram_stall = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 20'h00100, 8'h77});
        bus_strobe(20'h00100, 1'b1, 8'h77);
        k = 0;
        while (!sif.ram_request && k < 20) begin @(negedge clock); #1; k++; end
        n_total++;
        if (sif.ram_request !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_req_timeout got=%b required=1", sif.ram_request);
        end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_total++;
        if (sif.ram_request !== 1'b0 || sif.memory_access_ready !== 1'b1 ||
            sif.refresh_overrun !== 1'b0 || sif.ram_write !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_mid_access got req=%b rdy=%b ovr=%b wr=%b st=%0d required 0 1 0 0 0",
                     sif.ram_request, sif.memory_access_ready, sif.refresh_overrun,
                     sif.ram_write, dbg_state);
        end
        ram_stall = 1'b0;
        bus_release();
        @(negedge clock);
    endtask

    task automatic test_bus_read();
        int k;
        int early;
        do_reset();
        ram_latency = 3;
        exp_q.push_back({1'b0, 1'b0, 20'h12345, 8'hA5});
        bus_strobe(20'h12345, 1'b0, 8'h00);
        #1;
        n_total++;
        if (sif.memory_access_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL read_ready_on_strobe got=%b required=0", sif.memory_access_ready);
        end
        k = 0;
        early = 0;
        while (!sif.ram_done && k < 30) begin
            @(negedge clock); #1; k++;
            if (sif.memory_access_ready) early++;
        end
        n_total++;
        if (sif.ram_done !== 1'b1 || early != 0) begin
            n_bad++;
            $display("FAIL read_wait got done=%b ready_high=%0d required done=1 ready_high=0",
                     sif.ram_done, early);
        end
        n_total++;
        if (sif.ram_address !== 20'h12345 || sif.ram_write !== 1'b0) begin
            n_bad++;
            $display("FAIL read_attr got addr=%h wr=%b required 12345 0", sif.ram_address, sif.ram_write);
        end
        @(negedge clock); #1;
        n_total++;
        if (sif.memory_access_ready !== 1'b1 || sif.bus_read_data !== 8'hA5 || sif.ram_request !== 1'b0) begin
            n_bad++;
            $display("FAIL read_complete got rdy=%b data=%h req=%b required 1 a5 0",
                     sif.memory_access_ready, sif.bus_read_data, sif.ram_request);
        end
        bus_release();
        repeat (2) @(negedge clock);
        #1;
        n_total++;
        if (dbg_state !== ST_IDLE || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL read_end got st=%0d pending=%0d required 0 0", dbg_state, exp_q.size());
        end
    endtask

    task automatic test_refresh_bus_collision();
        int k;
        int hi;
        int start;
        do_reset();
        ram_latency = 2;
        exp_q.push_back({1'b1, 1'b0, 20'h00000, 8'h00});
        exp_q.push_back({1'b0, 1'b1, 20'h0ABCD, 8'h5A});
        while (cyc < N - 1) @(negedge clock);
        // strobe edge and counter wrap land on the same rising edge
        bus_strobe(20'h0ABCD, 1'b1, 8'h5A);
        start = done_seen;
        k = 0;
        hi = 0;
        while ((done_seen - start) < 2 && k < 60) begin
            @(negedge clock); #1; k++;
            if (sif.memory_access_ready) hi++;
        end
        n_total++;
        if ((done_seen - start) != 2 || hi != 0) begin
            n_bad++;
            $display("FAIL collide_wait got dones=%0d ready_high=%0d required 2 0", done_seen - start, hi);
        end
        @(negedge clock); #1;
        n_total++;
        if (sif.memory_access_ready !== 1'b1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL collide_end got rdy=%b pending=%0d required 1 0", sif.memory_access_ready, exp_q.size());
        end
        bus_release();
        repeat (2) @(negedge clock);
    endtask

    task automatic test_loader();
        int acks;
        int r0;
        do_reset();
        ram_latency = 2;
        exp_q.push_back({1'b0, 1'b1, 20'hF0000, 8'hEA});
        r0 = req_rises;
        sif.load_address = 20'hF0000;
        sif.load_data = 8'hEA;
        sif.load_request = 1'b1;
        acks = 0;
        repeat (30) begin
            @(negedge clock); #1;
            if (sif.load_ack) begin
                acks++;
                sif.load_request = 1'b0;
            end
        end
        n_total++;
        if (acks != 1 || (req_rises - r0) != 1 || dbg_state !== ST_IDLE || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL load_write got acks=%0d reqs=%0d st=%0d pending=%0d required 1 1 0 0",
                     acks, req_rises - r0, dbg_state, exp_q.size());
        end
        // held strobe: a single access, no repeat without a new edge
        exp_q.push_back({1'b0, 1'b0, 20'h00777, 8'h11});
        r0 = req_rises;
        bus_strobe(20'h00777, 1'b0, 8'h00);
        repeat (30) @(negedge clock);
        #1;
        n_total++;
        if ((req_rises - r0) != 1 || sif.bus_read_data !== 8'h11 || dbg_state !== ST_BUS_HOLD) begin
            n_bad++;
            $display("FAIL held_strobe got reqs=%0d data=%h st=%0d required 1 11 4",
                     req_rises - r0, sif.bus_read_data, dbg_state);
        end
        bus_release();
        repeat (2) @(negedge clock);
    endtask

    task automatic test_refresh_overrun();
        int k;
        do_reset();
        ram_latency = 1;
        ram_stall = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 20'h00042, 8'h99});
        bus_strobe(20'h00042, 1'b0, 8'h00);
        while (cyc < 2 * N - 1) @(negedge clock);
        #1;
        n_total++;
        if (sif.refresh_overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_early got=%b required=0", sif.refresh_overrun);
        end
        @(negedge clock); #1;
        n_total++;
        if (sif.refresh_overrun !== 1'b1 || sif.memory_access_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_set got ovr=%b rdy=%b required 1 0", sif.refresh_overrun, sif.memory_access_ready);
        end
        ram_stall = 1'b0;
        k = 0;
        while (!sif.ram_done && k < 20) begin @(negedge clock); #1; k++; end
        bus_release();
        repeat (12) @(negedge clock);
        #1;
        n_total++;
        if (sif.refresh_overrun !== 1'b1 || dbg_state !== ST_IDLE ||
            sif.bus_read_data !== 8'h99 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL overrun_sticky got ovr=%b st=%0d data=%h pending=%0d required 1 0 99 0",
                     sif.refresh_overrun, dbg_state, sif.bus_read_data, exp_q.size());
        end
    endtask

    task automatic test_bus_hold();
        int k;
        int r0;
        do_reset();
        ram_latency = 1;
        exp_q.push_back({1'b0, 1'b0, 20'h5A5A5, 8'h3C});
        r0 = req_rises;
        bus_strobe(20'h5A5A5, 1'b0, 8'h00);
        k = 0;
        while (!sif.ram_done && k < 20) begin @(negedge clock); #1; k++; end
        repeat (20) @(negedge clock);
        #1;
        n_total++;
        if (dbg_state !== ST_BUS_HOLD || (req_rises - r0) != 1 ||
            sif.memory_access_ready !== 1'b1 || sif.ram_request !== 1'b0) begin
            n_bad++;
            $display("FAIL bus_hold got st=%0d reqs=%0d rdy=%b req=%b required 4 1 1 0",
                     dbg_state, req_rises - r0, sif.memory_access_ready, sif.ram_request);
        end
        bus_release();
        repeat (2) @(negedge clock);
        #1;
        n_total++;
        if (dbg_state !== ST_IDLE || sif.bus_read_data !== 8'h3C || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL hold_exit got st=%0d data=%h pending=%0d required 0 3c 0",
                     dbg_state, sif.bus_read_data, exp_q.size());
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog got=timeout required=finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    // ---------------- sequence + report ----------------
    initial begin
        reset_n = 1'b0;
        test_reset();
        test_bus_read();
        test_refresh_bus_collision();
        test_loader();
        test_refresh_overrun();
        test_bus_hold();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
